// File: rtl/cmndf_pitch_picker_pkg.sv
// Shared constants and state encoding for the CMNDF pitch picker and its
// modiff_module neighbours.
package cmndf_pitch_picker_pkg;

    localparam int unsigned DATA_WIDTH       = 8;
    localparam int unsigned WINDOW_SIZE_BITS = 8;
    localparam int unsigned D_WIDTH          = 2 * DATA_WIDTH + WINDOW_SIZE_BITS;
    localparam int unsigned TAU_WIDTH        = 6;
    localparam int unsigned SUM_WIDTH        = D_WIDTH + TAU_WIDTH;
    localparam int unsigned THR_FRAC_BITS    = 8;
    localparam int unsigned THRESHOLD        = 38;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIP   = 2'd2
    } state_t;

endpackage

// File: rtl/cmndf_pitch_picker_ratio_cmp.sv
// Combinational ratio comparator: a_ge_b = (a_num/a_den >= b_num/b_den),
// evaluated as a_num*b_den >= b_num*a_den without division.
module cmndf_ratio_cmp
#(
    parameter int unsigned W = cmndf_pitch_picker_pkg::SUM_WIDTH
) (
    input  logic [W-1:0] a_num,
    input  logic [W-1:0] a_den,
    input  logic [W-1:0] b_num,
    input  logic [W-1:0] b_den,
    output logic         a_ge_b
);
    import cmndf_pitch_picker_pkg::*;

    logic [2*W-1:0] lhs;
    logic [2*W-1:0] rhs;

    always_comb begin
        lhs    = (2*W)'(a_num) * (2*W)'(b_den);
        rhs    = (2*W)'(b_num) * (2*W)'(a_den);
        a_ge_b = (lhs >= rhs);
    end

endmodule

// File: rtl/cmndf_pitch_picker.sv
// Picks the first sub-threshold local minimum of the cumulative-mean-normalized
// difference d'(tau). Optional argmin fallback: CMNDF_GLOBAL_MIN_FALLBACK_EN.
module cmndf_pitch_picker
#(
    parameter int unsigned DATA_WIDTH       = cmndf_pitch_picker_pkg::DATA_WIDTH,
    parameter int unsigned WINDOW_SIZE_BITS = cmndf_pitch_picker_pkg::WINDOW_SIZE_BITS,
    parameter int unsigned D_WIDTH          = 2 * DATA_WIDTH + WINDOW_SIZE_BITS,
    parameter int unsigned MAX_TAU          = 40,
    parameter int unsigned MIN_TAU          = 2,
    parameter int unsigned TAU_WIDTH        = cmndf_pitch_picker_pkg::TAU_WIDTH,
    parameter int unsigned THR_FRAC_BITS    = cmndf_pitch_picker_pkg::THR_FRAC_BITS,
    parameter int unsigned THRESHOLD        = cmndf_pitch_picker_pkg::THRESHOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [TAU_WIDTH-1:0] in_tau,
    input  logic [D_WIDTH-1:0]   in_d,
    output logic                 ready,
    output logic                 result_valid,
    output logic [TAU_WIDTH-1:0] result_tau,
    output logic                 result_found,
    output logic                 seq_error
);
    import cmndf_pitch_picker_pkg::*;

    localparam int unsigned SW = D_WIDTH + TAU_WIDTH;
    localparam int unsigned CW = SW + THR_FRAC_BITS;

    state_t               state_q, state_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [SW-1:0]        prev_num_q, prev_num_d;
    logic [SW-1:0]        prev_den_q, prev_den_d;
    logic [TAU_WIDTH-1:0] prev_tau_q, prev_tau_d;
    logic [TAU_WIDTH-1:0] exp_tau_q, exp_tau_d;
    logic [TAU_WIDTH-1:0] result_tau_q, result_tau_d;
    logic                 result_valid_q, result_valid_d;
    logic                 result_found_q, result_found_d;
    logic                 seq_error_q, seq_error_d;

    logic [SW-1:0]        num, den;
    logic                 active, tau_ok, take, last, eligible, below, rising;
    logic [TAU_WIDTH-1:0] fb_tau;

    always_comb begin : sample_decode
        num      = SW'(in_d) * SW'(in_tau);
        den      = sum_q + SW'(in_d);
        active   = in_valid && !start && (state_q != IDLE);
        tau_ok   = (in_tau == exp_tau_q);
        take     = active && tau_ok;
        last     = (in_tau == TAU_WIDTH'(MAX_TAU));
        eligible = (in_tau >= TAU_WIDTH'(MIN_TAU));
        // d' < THRESHOLD/2^F  <=>  num*2^F < THRESHOLD*den; zero den never qualifies
        below    = eligible && (den != '0) &&
                   ((CW'(num) << THR_FRAC_BITS) < (CW'(THRESHOLD) * CW'(den)));
    end

    cmndf_ratio_cmp #(.W(SW)) u_rise_cmp (
        .a_num  (num),
        .a_den  (den),
        .b_num  (prev_num_q),
        .b_den  (prev_den_q),
        .a_ge_b (rising)
    );

`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
    logic [SW-1:0]        min_num_q, min_num_d;
    logic [SW-1:0]        min_den_q, min_den_d;
    logic [TAU_WIDTH-1:0] min_tau_q, min_tau_d;
    logic                 min_valid_q, min_valid_d;
    logic                 not_lower, min_upd;

    cmndf_ratio_cmp #(.W(SW)) u_min_cmp (
        .a_num  (num),
        .a_den  (den),
        .b_num  (min_num_q),
        .b_den  (min_den_q),
        .a_ge_b (not_lower)
    );

    // Strict less-than keeps the earliest tau on ties; fb_tau includes the current sample.
    always_comb begin : fallback_next
        min_num_d   = min_num_q;
        min_den_d   = min_den_q;
        min_tau_d   = min_tau_q;
        min_valid_d = min_valid_q;
        min_upd     = take && eligible && (den != '0) && (!min_valid_q || !not_lower);
        if (start) begin
            min_num_d   = '0;
            min_den_d   = '0;
            min_tau_d   = TAU_WIDTH'(MIN_TAU);
            min_valid_d = 1'b0;
        end else if (min_upd) begin
            min_num_d   = num;
            min_den_d   = den;
            min_tau_d   = in_tau;
            min_valid_d = 1'b1;
        end
        fb_tau = min_upd ? in_tau : min_tau_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_num_q   <= '0;
            min_den_q   <= '0;
            min_tau_q   <= '0;
            min_valid_q <= 1'b0;
        end else begin
            min_num_q   <= min_num_d;
            min_den_q   <= min_den_d;
            min_tau_q   <= min_tau_d;
            min_valid_q <= min_valid_d;
        end
    end
`else
    assign fb_tau = '0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (start) begin
            state_d = ACCUM;
        end else if (take) begin
            case (state_q)
                ACCUM: begin
                    if (below)     state_d = DIP;
                    else if (last) state_d = IDLE;
                end
                DIP:     if (rising || last) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin : datapath_next
        sum_d          = sum_q;
        prev_num_d     = prev_num_q;
        prev_den_d     = prev_den_q;
        prev_tau_d     = prev_tau_q;
        exp_tau_d      = exp_tau_q;
        seq_error_d    = seq_error_q;
        result_valid_d = 1'b0;
        result_found_d = result_found_q;
        result_tau_d   = result_tau_q;
        if (start) begin
            sum_d       = '0;
            prev_num_d  = '0;
            prev_den_d  = '0;
            prev_tau_d  = '0;
            exp_tau_d   = TAU_WIDTH'(1);
            seq_error_d = 1'b0;
        end else if (active && !tau_ok) begin
            seq_error_d = 1'b1;
        end else if (take) begin
            sum_d     = den;
            exp_tau_d = exp_tau_q + 1'b1;
            case (state_q)
                ACCUM: begin
                    if (below) begin
                        prev_num_d = num;
                        prev_den_d = den;
                        prev_tau_d = in_tau;
                    end else if (last) begin
                        result_valid_d = 1'b1;
                        result_found_d = 1'b0;
                        result_tau_d   = fb_tau;
                    end
                end
                DIP: begin
                    if (rising) begin
                        result_valid_d = 1'b1;
                        result_found_d = 1'b1;
                        result_tau_d   = prev_tau_q;
                    end else begin
                        prev_num_d = num;
                        prev_den_d = den;
                        prev_tau_d = in_tau;
                        if (last) begin
                            result_valid_d = 1'b1;
                            result_found_d = 1'b1;
                            result_tau_d   = in_tau;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (reset) begin
            sum_q          <= '0;
            prev_num_q     <= '0;
            prev_den_q     <= '0;
            prev_tau_q     <= '0;
            exp_tau_q      <= '0;
            seq_error_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_found_q <= 1'b0;
            result_tau_q   <= '0;
        end else begin
            sum_q          <= sum_d;
            prev_num_q     <= prev_num_d;
            prev_den_q     <= prev_den_d;
            prev_tau_q     <= prev_tau_d;
            exp_tau_q      <= exp_tau_d;
            seq_error_q    <= seq_error_d;
            result_valid_q <= result_valid_d;
            result_found_q <= result_found_d;
            result_tau_q   <= result_tau_d;
        end
    end

    always_comb begin : outputs
        ready        = (state_q == IDLE);
        result_valid = result_valid_q;
        result_found = result_found_q;
        result_tau   = result_tau_q;
        seq_error    = seq_error_q;
    end

endmodule

// File: tb/tb_cmndf_pitch_picker.sv
// Directed bench for cmndf_pitch_picker with a frame-level reference model;
// honours CMNDF_GLOBAL_MIN_FALLBACK_EN when defined.
module tb_cmndf_pitch_picker;

    localparam int MIN_T = 2;
    localparam int MAX_T = 40;
    localparam longint unsigned THR = 38;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_tau = '0;
    logic [23:0] in_d = '0;
    logic        ready, result_valid, result_found, seq_error;
    logic [5:0]  result_tau;

    cmndf_pitch_picker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_tau       (in_tau),
        .in_d         (in_d),
        .ready        (ready),
        .result_valid (result_valid),
        .result_tau   (result_tau),
        .result_found (result_found),
        .seq_error    (seq_error)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    bit chk_en = 0;

    // scoreboard expectations
    int exp_cyc = -1;
    int exp_tau_n = 0;
    bit exp_found_n = 0;
    int held_tau = 0;
    bit held_found = 0;
    bit exp_seq = 0;
    bit busy = 0;

    int fr_tau[$];
    int fr_d[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    endfunction

    // Reference: filter in-order samples, form d' ratios, find the first
    // sub-threshold tau and follow the strict descent to its bottom.
    function automatic void model(output int dec_idx, output bit found, output int rtau,
                                  output int err_idx);
        longint unsigned nm[64];
        longint unsigned dn[64];
        int acc[64];
        int n = 0;
        longint unsigned s = 0;
        int first = -1;
        int t;
        dec_idx = -1; found = 0; rtau = 0; err_idx = -1;
        for (int i = 0; i < fr_tau.size(); i++) begin
            if (fr_tau[i] != n + 1) begin
                if (err_idx < 0) err_idx = i;
                continue;
            end
            n++;
            s += longint'(fr_d[i]);
            nm[n] = longint'(fr_d[i]) * longint'(n);
            dn[n] = s;
            acc[n] = i;
        end
        for (int k = MIN_T; k <= n; k++)
            if (dn[k] != 0 && nm[k] * 256 < THR * dn[k]) begin first = k; break; end
        if (first > 0) begin
            t = first;
            while (t < n && nm[t+1] * dn[t] < nm[t] * dn[t+1]) t++;
            if (t < n) begin
                dec_idx = acc[t+1]; found = 1; rtau = t;
            end else if (t == MAX_T && first < MAX_T) begin
                dec_idx = acc[t]; found = 1; rtau = t;
            end
        end else if (n >= MAX_T) begin
            dec_idx = acc[MAX_T];
            found = 0;
            rtau = 0;
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
            begin
                int best = -1;
                for (int k = MIN_T; k <= MAX_T; k++)
                    if (dn[k] != 0 && (best < 0 || nm[k] * dn[best] < nm[best] * dn[k])) best = k;
                rtau = (best < 0) ? MIN_T : best;
            end
`endif
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = (cyc == exp_cyc);
            if (ev) begin
                held_tau = exp_tau_n;
                held_found = exp_found_n;
            end
            if (result_valid === 1'b1) pulse_cnt++;
            chk("result_valid", result_valid, ev);
            chk("result_tau", result_tau, held_tau);
            chk("result_found", result_found, held_found);
            chk("seq_error", seq_error, exp_seq);
            chk("ready", ready, !busy);
        end
    end

    task automatic drive(input bit s, input bit v, input int t, input int d);
        start = s;
        in_valid = v;
        in_tau = 6'(t);
        in_d = 24'(d);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        busy = 0; held_tau = 0; held_found = 0; exp_seq = 0; exp_cyc = -1;
    endtask

    task automatic send_frame(input bit with_start);
        int dec, err, rt;
        bit fnd;
        model(dec, fnd, rt, err);
        if (with_start) begin
            drive(1, 0, 0, 0);
            exp_seq = 0;
            busy = 1;
        end
        for (int i = 0; i < fr_tau.size(); i++) begin
            if (i % 5 == 3) drive(0, 0, 0, 0);
            drive(0, 1, fr_tau[i], fr_d[i]);
            if (i == err) exp_seq = 1;
            if (i == dec) begin
                exp_cyc = cyc; exp_tau_n = rt; exp_found_n = fnd; busy = 0;
            end
        end
        repeat (2) drive(0, 0, 0, 0);
    endtask

    task automatic build_flat(input int n, input int val);
        fr_tau.delete();
        fr_d.delete();
        for (int t = 1; t <= n; t++) begin
            fr_tau.push_back(t);
            fr_d.push_back(val);
        end
    endtask

    task automatic build_dip();
        build_flat(MAX_T, 1000);
        fr_d[9] = 20; fr_d[10] = 5; fr_d[11] = 40;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dec, err, rt, p0, fb;
        bit fnd;
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
        fb = 2;
`else
        fb = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;
        chk("rst_ready", ready, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_tau", result_tau, 0);
        chk("rst_seq_error", seq_error, 0);

        // model pinned by hand-derived values
        build_dip();
        model(dec, fnd, rt, err);
        chk("model_dip_tau", rt, 11);
        chk("model_dip_decide_idx", dec, 11);

        build_dip();
        send_frame(1);
        chk("dip_tau", result_tau, 11);
        chk("dip_found", result_found, 1);
        chk("dip_ready", ready, 1);

        build_flat(MAX_T, 1000);
        send_frame(1);
        chk("flat_found", result_found, 0);
        chk("flat_tau", result_tau, fb);

        build_flat(MAX_T, 0);
        send_frame(1);
        chk("silence_found", result_found, 0);
        chk("silence_tau", result_tau, fb);
        chk("silence_seq", seq_error, 0);

        build_flat(MAX_T, 1000);
        fr_d[36] = 10; fr_d[37] = 8; fr_d[38] = 5; fr_d[39] = 2;
        send_frame(1);
        chk("enddip_tau", result_tau, 40);
        chk("enddip_found", result_found, 1);

        // tau 4 out of order with a huge d that must not reach the sum
        fr_tau.delete(); fr_d.delete();
        fr_tau.push_back(1); fr_d.push_back(1000);
        fr_tau.push_back(2); fr_d.push_back(1000);
        fr_tau.push_back(4); fr_d.push_back(500000);
        for (int t = 3; t <= MAX_T; t++) begin
            fr_tau.push_back(t);
            fr_d.push_back(1000);
        end
        send_frame(1);
        chk("seq_sticky", seq_error, 1);
        chk("seq_found", result_found, 0);
        drive(1, 0, 0, 0);
        exp_seq = 0; busy = 1;
        chk("seq_cleared", seq_error, 0);

        // start coinciding with tau=5 aborts the frame; only the second one reports
        p0 = pulse_cnt;
        build_flat(4, 1000);
        send_frame(1);
        drive(1, 1, 5, 1000);
        exp_seq = 0; busy = 1;
        build_dip();
        send_frame(0);
        chk("abort_pulses", pulse_cnt - p0, 1);
        chk("abort_tau", result_tau, 11);

        // reset while in DIP, then late samples in IDLE must be ignored
        build_dip();
        while (fr_tau.size() > 10) begin
            void'(fr_tau.pop_back());
            void'(fr_d.pop_back());
        end
        send_frame(1);
        p0 = pulse_cnt;
        do_reset();
        chk("midrst_ready", ready, 1);
        chk("midrst_tau", result_tau, 0);
        chk("midrst_found", result_found, 0);
        drive(0, 1, 11, 5);
        drive(0, 1, 12, 40);
        repeat (3) drive(0, 0, 0, 0);
        chk("midrst_no_pulse", pulse_cnt - p0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
